qbert_cube_ctrl: RTL and testbench

- Owns the game state of the Qbert pyramid: one "visited" bit per cube, set when Qbert lands on that cube.
- Supplies the top_cube colour select to the map renderer for whichever cube index the renderer is drawing.
- Sequences the level: play, then a completion flash, then clear and advance the level.
- Sits between the Qbert movement logic (landing events) and the map/cube-generator datapath (per-pixel colour choice).

---
 rtl/qbert_pkg.sv | 26 ++
 rtl/qbert_flash_timer.sv | 53 +++++
 rtl/qbert_cube_ctrl.sv | 135 +++++++++++++
 tb/tb_qbert_cube_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/qbert_pkg.sv
// Shared Qbert definitions: controller state encoding, default pyramid
// geometry and the cube palette used by both the map renderer and the
// cube controller.
package qbert_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    CLEAR = 2'd2
  } qbert_state_t;

  localparam int QB_N_CUBES = 5;
  localparam int QB_IDX_W   = 4;

  // 12-bit RGB palette for one cube
  localparam logic [11:0] COL_TOP_VISITED   = 12'hFF0;
  localparam logic [11:0] COL_TOP_UNVISITED = 12'h00F;
  localparam logic [11:0] COL_LEFT          = 12'h0A4;
  localparam logic [11:0] COL_RIGHT         = 12'h052;

  // Map the controller's top_cube select onto the top-face colour
  function automatic logic [11:0] top_colour(input logic sel);
    return sel ? COL_TOP_VISITED : COL_TOP_UNVISITED;
  endfunction

endpackage

// File: rtl/qbert_flash_timer.sv
// Completion-flash timer: counts frame ticks while enabled, toggles the
// flash phase every FLASH_PERIOD counted frames and reports done once
// FLASH_FRAMES frames have been counted. The count saturates at done.
module qbert_flash_timer #(
  parameter int FLASH_FRAMES = 16,
  parameter int FLASH_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic frame_tick,
  output logic phase,
  output logic done
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam int SUB_W = $clog2(FLASH_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(FLASH_FRAMES);
  localparam logic [SUB_W-1:0] SUB_END = SUB_W'(FLASH_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [SUB_W-1:0] r_sub;
  logic             r_phase;
  logic             w_step;

  assign w_step = en && frame_tick && (r_cnt != CNT_END);

  // Frame counter, half-period sub-counter and phase toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_sub   <= '0;
      r_phase <= 1'b0;
    end else if (clr) begin
      r_cnt   <= '0;
      r_sub   <= '0;
      r_phase <= 1'b0;
    end else if (w_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_sub == SUB_END) begin
        r_sub   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_sub <= r_sub + 1'b1;
      end
    end
  end

  assign phase = r_phase;
  assign done  = (r_cnt == CNT_END);

endmodule

// File: rtl/qbert_cube_ctrl.sv
// Qbert pyramid controller: tracks which cubes have been landed on,
// answers the renderer's per-cube top colour query with one clock of
// latency and sequences PLAY -> FLASH -> CLEAR -> PLAY per level.
module qbert_cube_ctrl
  import qbert_pkg::*;
#(
  parameter int N_CUBES      = QB_N_CUBES,
  parameter int IDX_W        = QB_IDX_W,
  parameter int FLASH_FRAMES = 16,
  parameter int FLASH_PERIOD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               restart,
  input  logic               land_valid,
  input  logic [IDX_W-1:0]   land_idx,
  output logic               land_ready,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               top_cube,
  output logic [N_CUBES-1:0] visited,
  output logic [3:0]         level,
  output logic               level_done,
  output logic               flashing
);

  qbert_state_t       r_state;
  logic [N_CUBES-1:0] r_visited;
  logic [3:0]         r_level;
  logic               r_level_done;
  logic               r_top_cube;

  logic [N_CUBES-1:0] w_land_hot;
  logic [N_CUBES-1:0] w_rd_hot;
  logic [N_CUBES-1:0] w_visited_upd;
  logic               w_accept;
  logic               w_complete;
  logic               w_timer_clr;
  logic               w_flash_en;
  logic               w_flash_phase;
  logic               w_flash_done;

  // Decode landing and read indices to one-hot; out-of-range decodes to zero
  always_comb begin
    w_land_hot = '0;
    w_rd_hot   = '0;
    for (int i = 0; i < N_CUBES; i++) begin
      w_land_hot[i] = (land_idx == IDX_W'(i));
      w_rd_hot[i]   = (rd_idx == IDX_W'(i));
    end
  end

  // restart wins over a same-cycle landing, so the event is simply dropped
  assign w_accept      = land_valid && land_ready && !restart;
  assign w_visited_upd = r_visited | (w_accept ? w_land_hot : '0);
  assign w_complete    = w_accept && (|w_land_hot) && (&w_visited_upd);

  // Counter is zeroed on the completion cycle, so a frame_start in that
  // same cycle is never counted; counting starts once FLASH is entered.
  assign w_timer_clr = restart || w_complete;
  assign w_flash_en  = (r_state == FLASH);

  qbert_flash_timer #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_PERIOD (FLASH_PERIOD)
  ) u_flash_timer (
    .clk        (clk),
    .rst_n      (reset),
    .clr        (w_timer_clr),
    .en         (w_flash_en),
    .frame_tick (frame_start),
    .phase      (w_flash_phase),
    .done       (w_flash_done)
  );

  // Level sequencer, visited bitmap and completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= PLAY;
      r_visited    <= '0;
      r_level      <= 4'd0;
      r_level_done <= 1'b0;
    end else if (restart) begin
      r_state      <= PLAY;
      r_visited    <= '0;
      r_level      <= 4'd0;
      r_level_done <= 1'b0;
    end else begin
      r_level_done <= 1'b0;
      case (r_state)
        PLAY: begin
          r_visited <= w_visited_upd;
          if (w_complete) begin
            r_level_done <= 1'b1;
            r_state      <= FLASH;
          end
        end
        FLASH: begin
          if (w_flash_done) begin
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_visited <= '0;
          r_level   <= r_level + 4'd1;
          r_state   <= PLAY;
        end
        default: begin
          r_state <= PLAY;
        end
      endcase
    end
  end

  // Registered top-face select for the cube the renderer is asking about
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_top_cube <= 1'b0;
    end else if (~|w_rd_hot) begin
      r_top_cube <= 1'b0;
    end else if (r_state == FLASH) begin
      r_top_cube <= w_flash_phase;
    end else begin
      r_top_cube <= |(r_visited & w_rd_hot);
    end
  end

  assign land_ready = (r_state == PLAY);
  assign flashing   = (r_state == FLASH);
  assign top_cube   = r_top_cube;
  assign visited    = r_visited;
  assign level      = r_level;
  assign level_done = r_level_done;

endmodule

// File: tb/tb_qbert_cube_ctrl.sv
// Self-checking bench for qbert_cube_ctrl. top_cube expectations go
// through a scoreboard queue: pushed when rd_idx is driven, popped one
// clock later when the registered answer appears.
module tb_qbert_cube_ctrl;

  localparam int N  = 5;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          restart = 1'b0;
  logic          land_valid = 1'b0;
  logic [IW-1:0] land_idx = '0;
  logic [IW-1:0] rd_idx = '0;
  logic          land_ready;
  logic          top_cube;
  logic [N-1:0]  visited;
  logic [3:0]    level;
  logic          level_done;
  logic          flashing;

  int   n_checks = 0;
  int   n_fail = 0;
  logic exp_q[$];
  logic exp_top;

  always #5 clk = ~clk;

  qbert_cube_ctrl #(
    .N_CUBES(N), .IDX_W(IW), .FLASH_FRAMES(16), .FLASH_PERIOD(4)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .restart(restart),
    .land_valid(land_valid), .land_idx(land_idx), .land_ready(land_ready),
    .rd_idx(rd_idx), .top_cube(top_cube), .visited(visited), .level(level),
    .level_done(level_done), .flashing(flashing)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(); cyc();
    n_checks++; if (land_ready !== 1'b1) begin n_fail++; $display("FAIL reset_land_ready: got %b want 1", land_ready); end
    n_checks++; if (visited !== 5'b00000) begin n_fail++; $display("FAIL reset_visited: got %b want 00000", visited); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (level_done !== 1'b0) begin n_fail++; $display("FAIL reset_level_done: got %b want 0", level_done); end
    n_checks++; if (flashing !== 1'b0) begin n_fail++; $display("FAIL reset_flashing: got %b want 0", flashing); end
    n_checks++; if (top_cube !== 1'b0) begin n_fail++; $display("FAIL reset_top_cube: got %b want 0", top_cube); end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_idx = IW'(i);
      exp_q.push_back(1'b0);
      cyc();
      exp_top = exp_q.pop_front();
      n_checks++; if (top_cube !== exp_top) begin n_fail++; $display("FAIL reset_read idx %0d: got %b want %b", i, top_cube, exp_top); end
    end
  endtask

  task automatic test_land_basic();
    land_valid = 1'b1; land_idx = 4'd2; rd_idx = 4'd2;
    exp_q.push_back(1'b0);
    cyc();
    exp_top = exp_q.pop_front();
    n_checks++; if (top_cube !== exp_top) begin n_fail++; $display("FAIL land_same_cycle_read: got %b want %b", top_cube, exp_top); end
    n_checks++; if (visited !== 5'b00100) begin n_fail++; $display("FAIL land2_visited: got %b want 00100", visited); end
    land_idx = 4'd2; rd_idx = 4'd2;
    exp_q.push_back(1'b1);
    cyc();
    exp_top = exp_q.pop_front();
    n_checks++; if (top_cube !== exp_top) begin n_fail++; $display("FAIL land_next_cycle_read: got %b want %b", top_cube, exp_top); end
    n_checks++; if (visited !== 5'b00100) begin n_fail++; $display("FAIL reland_visited: got %b want 00100", visited); end
    land_idx = 4'd7; rd_idx = 4'd7;
    exp_q.push_back(1'b0);
    cyc();
    exp_top = exp_q.pop_front();
    n_checks++; if (top_cube !== exp_top) begin n_fail++; $display("FAIL oor_read: got %b want %b", top_cube, exp_top); end
    n_checks++; if (visited !== 5'b00100) begin n_fail++; $display("FAIL oor_land_visited: got %b want 00100", visited); end
    n_checks++; if (level_done !== 1'b0) begin n_fail++; $display("FAIL basic_level_done: got %b want 0", level_done); end
    land_valid = 1'b0;
  endtask

  task automatic test_level_complete();
    for (int k = 0; k < 5; k++) begin
      land_valid = 1'b1; land_idx = IW'(k);
      cyc();
      n_checks++; if (level_done !== (k == 4)) begin n_fail++; $display("FAIL complete_level_done idx %0d: got %b want %b", k, level_done, (k == 4)); end
    end
    land_valid = 1'b0;
    n_checks++; if (flashing !== 1'b1) begin n_fail++; $display("FAIL complete_flashing: got %b want 1", flashing); end
    n_checks++; if (land_ready !== 1'b0) begin n_fail++; $display("FAIL complete_land_ready: got %b want 0", land_ready); end
    n_checks++; if (visited !== 5'b11111) begin n_fail++; $display("FAIL complete_visited: got %b want 11111", visited); end
    rd_idx = 4'd1;
    cyc();
    n_checks++; if (level_done !== 1'b0) begin n_fail++; $display("FAIL level_done_width: got %b want 0", level_done); end
    for (int f = 1; f <= 16; f++) begin
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      exp_q.push_back(((f / 4) % 2) == 1);
      cyc();
      exp_top = exp_q.pop_front();
      n_checks++; if (top_cube !== exp_top) begin n_fail++; $display("FAIL flash_phase frame %0d: got %b want %b", f, top_cube, exp_top); end
      n_checks++; if (flashing !== (f < 16)) begin n_fail++; $display("FAIL flash_flag frame %0d: got %b want %b", f, flashing, (f < 16)); end
    end
    n_checks++; if (land_ready !== 1'b0) begin n_fail++; $display("FAIL clear_land_ready: got %b want 0", land_ready); end
    n_checks++; if (visited !== 5'b11111) begin n_fail++; $display("FAIL clear_visited_hold: got %b want 11111", visited); end
    rd_idx = 4'd1;
    exp_q.push_back(1'b1);
    cyc();
    exp_top = exp_q.pop_front();
    n_checks++; if (top_cube !== exp_top) begin n_fail++; $display("FAIL clear_read: got %b want %b", top_cube, exp_top); end
    n_checks++; if (visited !== 5'b00000) begin n_fail++; $display("FAIL after_clear_visited: got %b want 00000", visited); end
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL after_clear_level: got %0d want 1", level); end
    n_checks++; if (land_ready !== 1'b1) begin n_fail++; $display("FAIL after_clear_land_ready: got %b want 1", land_ready); end
  endtask

  task automatic test_flash_ignores_valid();
    for (int k = 0; k < 5; k++) begin
      land_valid = 1'b1; land_idx = IW'(k);
      cyc();
    end
    n_checks++; if (flashing !== 1'b1) begin n_fail++; $display("FAIL ign_flashing: got %b want 1", flashing); end
    land_idx = 4'd1; rd_idx = 4'd9; frame_start = 1'b1;
    for (int f = 0; f < 16; f++) begin
      exp_q.push_back(1'b0);
      cyc();
      exp_top = exp_q.pop_front();
      n_checks++; if (top_cube !== exp_top) begin n_fail++; $display("FAIL flash_oor_read cycle %0d: got %b want %b", f, top_cube, exp_top); end
    end
    frame_start = 1'b0;
    cyc();
    n_checks++; if (land_ready !== 1'b0) begin n_fail++; $display("FAIL ign_clear_ready: got %b want 0", land_ready); end
    n_checks++; if (visited !== 5'b11111) begin n_fail++; $display("FAIL ign_clear_visited: got %b want 11111", visited); end
    cyc();
    n_checks++; if (visited !== 5'b00000) begin n_fail++; $display("FAIL ign_play_visited: got %b want 00000", visited); end
    n_checks++; if (level !== 4'd2) begin n_fail++; $display("FAIL ign_level: got %0d want 2", level); end
    n_checks++; if (land_ready !== 1'b1) begin n_fail++; $display("FAIL ign_land_ready: got %b want 1", land_ready); end
    cyc();
    land_valid = 1'b0;
    n_checks++; if (visited !== 5'b00010) begin n_fail++; $display("FAIL ign_first_accept: got %b want 00010", visited); end
  endtask

  task automatic test_restart_collision();
    land_valid = 1'b1;
    land_idx = 4'd0; cyc();
    land_idx = 4'd2; cyc();
    land_idx = 4'd3; cyc();
    n_checks++; if (visited !== 5'b01111) begin n_fail++; $display("FAIL pre_restart_visited: got %b want 01111", visited); end
    land_idx = 4'd4; restart = 1'b1;
    cyc();
    restart = 1'b0; land_valid = 1'b0;
    n_checks++; if (level_done !== 1'b0) begin n_fail++; $display("FAIL restart_level_done: got %b want 0", level_done); end
    n_checks++; if (flashing !== 1'b0) begin n_fail++; $display("FAIL restart_flashing: got %b want 0", flashing); end
    n_checks++; if (land_ready !== 1'b1) begin n_fail++; $display("FAIL restart_land_ready: got %b want 1", land_ready); end
    n_checks++; if (visited !== 5'b00000) begin n_fail++; $display("FAIL restart_visited: got %b want 00000", visited); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL restart_level: got %0d want 0", level); end
    cyc();
    n_checks++; if (level_done !== 1'b0) begin n_fail++; $display("FAIL restart_level_done_late: got %b want 0", level_done); end
  endtask

  task automatic test_async_reset_mid_flash();
    for (int k = 0; k < 5; k++) begin
      land_valid = 1'b1; land_idx = IW'(k);
      cyc();
    end
    land_valid = 1'b0; rd_idx = 4'd0; frame_start = 1'b1;
    repeat (7) cyc();
    frame_start = 1'b0;
    exp_q.push_back(1'b1);
    cyc();
    exp_top = exp_q.pop_front();
    n_checks++; if (top_cube !== exp_top) begin n_fail++; $display("FAIL mid_flash_phase: got %b want %b", top_cube, exp_top); end
    n_checks++; if (flashing !== 1'b1) begin n_fail++; $display("FAIL mid_flash_flag: got %b want 1", flashing); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (flashing !== 1'b0) begin n_fail++; $display("FAIL async_flashing: got %b want 0", flashing); end
    n_checks++; if (visited !== 5'b00000) begin n_fail++; $display("FAIL async_visited: got %b want 00000", visited); end
    n_checks++; if (top_cube !== 1'b0) begin n_fail++; $display("FAIL async_top_cube: got %b want 0", top_cube); end
    n_checks++; if (land_ready !== 1'b1) begin n_fail++; $display("FAIL async_land_ready: got %b want 1", land_ready); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL async_level: got %0d want 0", level); end
    cyc();
    reset = 1'b1;
    land_valid = 1'b1; land_idx = 4'd3;
    cyc();
    land_valid = 1'b0;
    n_checks++; if (visited !== 5'b01000) begin n_fail++; $display("FAIL post_reset_land: got %b want 01000", visited); end
    land_valid = 1'b1;
    land_idx = 4'd0; cyc();
    land_idx = 4'd1; cyc();
    land_idx = 4'd2; cyc();
    land_idx = 4'd4; cyc();
    land_valid = 1'b0;
    n_checks++; if (flashing !== 1'b1) begin n_fail++; $display("FAIL post_reset_flash: got %b want 1", flashing); end
    rd_idx = 4'd0; frame_start = 1'b1;
    repeat (3) cyc();
    frame_start = 1'b0;
    exp_q.push_back(1'b0);
    cyc();
    exp_top = exp_q.pop_front();
    n_checks++; if (top_cube !== exp_top) begin n_fail++; $display("FAIL post_reset_phase: got %b want %b", top_cube, exp_top); end
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    exp_q.push_back(1'b1);
    cyc();
    exp_top = exp_q.pop_front();
    n_checks++; if (top_cube !== exp_top) begin n_fail++; $display("FAIL post_reset_phase4: got %b want %b", top_cube, exp_top); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_land_basic();
    test_level_complete();
    test_flash_ignores_valid();
    test_restart_collision();
    test_async_reset_mid_flash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
